// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART receive path.
package uart_pkg;

   localparam int DATA_BITS_DEF = 8;
   localparam int OVERSAMPLING  = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RECV = 2'd1,
      S_GAP  = 2'd2
   } state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is taken
// only when a pop frees a slot at the same edge.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DATA_BITS_DEF,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        push_in,
   input  logic                        pop_in,
   input  logic [DATA_BITS-1:0]        wr_data_in,
   output logic [DATA_BITS-1:0]        rd_data_out,
   output logic [$clog2(FIFO_DEPTH):0] count_out,
   output logic                        full_out,
   output logic                        empty_out
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 do_push, do_pop;

   always_comb begin
      empty_out = (count_q == '0);
      full_out  = (count_q == CW'(FIFO_DEPTH));
      do_pop    = pop_in & ~empty_out;
      do_push   = push_in & (~full_out | do_pop);
      wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d   = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; the empty flag masks stale entries.
   always_ff @(posedge clk_in) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_in;
   end

   assign rd_data_out = empty_out ? '0 : mem_q[rd_ptr_q];
   assign count_out   = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: captures receiver bytes into a FIFO, flags overrun and,
// with UART_RX_CTRL_IDLE_TIMEOUT_EN defined, pulses idle_out on inter-byte gaps.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS      = DATA_BITS_DEF,
   parameter int FIFO_DEPTH     = 16,
   parameter int TIMEOUT_CYCLES = 160
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        en_in,
   input  logic                        rx_rdy_in,
   input  logic [DATA_BITS-1:0]        rx_data_in,
   output logic                        m_valid_out,
   input  logic                        m_ready_in,
   output logic [DATA_BITS-1:0]        m_data_out,
   output logic [$clog2(FIFO_DEPTH):0] count_out,
   output logic                        overrun_out,
   input  logic                        clr_in,
   output logic                        idle_out
);

   logic   rdy_q, rdy_d;
   logic   overrun_q, overrun_d;
   state_e state_q, state_d;
   logic   push, pop, fifo_full, fifo_empty;

   assign m_valid_out = ~fifo_empty;
   assign pop         = m_valid_out & m_ready_in;
   assign push        = rx_rdy_in & ~rdy_q & en_in;

   uart_sync_fifo #(
      .DATA_BITS (DATA_BITS),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .push_in    (push),
      .pop_in     (pop),
      .wr_data_in (rx_data_in),
      .rd_data_out(m_data_out),
      .count_out  (count_out),
      .full_out   (fifo_full),
      .empty_out  (fifo_empty)
   );

   // Setting overrun takes priority over a clear in the same cycle.
   always_comb begin
      rdy_d     = rx_rdy_in;
      overrun_d = overrun_q;
      if (push && fifo_full && !pop) overrun_d = 1'b1;
      else if (clr_in)               overrun_d = 1'b0;
   end

`ifdef UART_RX_CTRL_IDLE_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] timer_q, timer_d;
   logic          idle_q, idle_d;

   // Silence is only counted while enabled; any byte restarts the gap timer.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (push) state_d = S_RECV;
         end
         S_RECV: begin
            if (push || !en_in) begin
               timer_d = '0;
            end else if (timer_q == TIMER_LAST) begin
               state_d = S_GAP;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_GAP: begin
            timer_d = '0;
            state_d = push ? S_RECV : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
         end
      endcase
      idle_d = (state_d == S_GAP);
   end

   assign idle_out = idle_q;
`else
   logic unused_cfg;

   always_comb begin
      state_d = state_q;
      if (state_q != S_RECV && push) state_d = S_RECV;
   end

   assign idle_out   = 1'b0;
   assign unused_cfg = |TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rdy_q     <= 1'b0;
         overrun_q <= 1'b0;
         state_q   <= S_IDLE;
`ifdef UART_RX_CTRL_IDLE_TIMEOUT_EN
         timer_q   <= '0;
         idle_q    <= 1'b0;
`endif
      end else begin
         rdy_q     <= rdy_d;
         overrun_q <= overrun_d;
         state_q   <= state_d;
`ifdef UART_RX_CTRL_IDLE_TIMEOUT_EN
         timer_q   <= timer_d;
         idle_q    <= idle_d;
`endif
      end
   end

   assign overrun_out = overrun_q;

endmodule
